// File: rtl/button_event_scan.sv
// Four-button scanner: synchronize and debounce each pin, detect press/release/long-press,
// and queue the resulting events through per-button pending slots into a 4-deep FIFO.
module button_event_scan #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned LONG_CYCLES     = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_n,
  output logic [3:0] btn_state,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [3:0] ev_code,
  output logic       ev_overflow
);

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  localparam logic [1:0]  EV_PRESS   = 2'b01;
  localparam logic [1:0]  EV_RELEASE = 2'b10;
  localparam logic [1:0]  EV_LONG    = 2'b11;
  localparam logic [23:0] DB_LAST    = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] LG_LAST    = 24'(LONG_CYCLES - 1);
  localparam logic [23:0] LG_PRE     = 24'(LONG_CYCLES - 2);

  logic [3:0]  sync1, sync2, raw_pressed;
  state_t      state_q [4];
  state_t      state_d [4];
  logic [23:0] cnt_q [4];
  logic [23:0] cnt_d [4];
  logic [3:0]  long_q, long_d;
  logic [3:0]  post_v_q, post_v_d;
  logic [1:0]  post_t_q [4];
  logic [1:0]  post_t_d [4];
  logic [3:0]  pend_v_q, pend_v_d;
  logic [1:0]  pend_t_q [4];
  logic [1:0]  pend_t_d [4];
  logic        ovf_set;
  logic [3:0]  fifo_mem [4];
  logic [1:0]  rd_ptr, wr_ptr;
  logic [2:0]  count;
  logic        pop, can_push, move;
  logic [1:0]  sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign raw_pressed = ~sync2;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      long_d[i]   = long_q[i];
      post_v_d[i] = 1'b0;
      post_t_d[i] = 2'b00;
      case (state_q[i])
        RELEASED: begin
          if (raw_pressed[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!raw_pressed[i]) begin
            state_d[i] = RELEASED;
            long_d[i]  = 1'b0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i]  = PRESSED;
            cnt_d[i]    = '0;
            post_v_d[i] = 1'b1;
            post_t_d[i] = EV_PRESS;
          end else begin
            cnt_d[i] = cnt_q[i] + 24'd1;
          end
        end
        PRESSED: begin
          if (!raw_pressed[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] != LG_LAST) begin
            cnt_d[i] = cnt_q[i] + 24'd1;
            if (cnt_q[i] == LG_PRE && !long_q[i]) begin
              long_d[i]   = 1'b1;
              post_v_d[i] = 1'b1;
              post_t_d[i] = EV_LONG;
            end
          end
        end
        RELEASE_WAIT: begin
          // A bounce back keeps the saturated count so a posted long event cannot repeat.
          if (raw_pressed[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = long_q[i] ? LG_LAST : '0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i]  = RELEASED;
            long_d[i]   = 1'b0;
            post_v_d[i] = 1'b1;
            post_t_d[i] = EV_RELEASE;
          end else begin
            cnt_d[i] = cnt_q[i] + 24'd1;
          end
        end
      endcase
    end
  end

  // Events and btn_state are registered once more after the FSM, giving the E+D+3 latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i]  <= RELEASED;
        cnt_q[i]    <= '0;
        post_t_q[i] <= '0;
      end
      long_q    <= '0;
      post_v_q  <= '0;
      btn_state <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i]   <= state_d[i];
        cnt_q[i]     <= cnt_d[i];
        post_t_q[i]  <= post_t_d[i];
        btn_state[i] <= (state_q[i] == PRESSED) || (state_q[i] == RELEASE_WAIT);
      end
      long_q   <= long_d;
      post_v_q <= post_v_d;
    end
  end

  assign ev_valid = (count != 3'd0);
  assign ev_code  = fifo_mem[rd_ptr];
  assign pop      = ev_valid && ev_ready;
  assign can_push = (count != 3'd4) || pop;

  always_comb begin
    move    = 1'b0;
    sel     = 2'd0;
    ovf_set = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!move && pend_v_q[i] && can_push) begin
        move = 1'b1;
        sel  = 2'(i);
      end
    end
    for (int unsigned i = 0; i < 4; i++) begin
      pend_v_d[i] = pend_v_q[i];
      pend_t_d[i] = pend_t_q[i];
      if (post_v_q[i]) begin
        pend_v_d[i] = 1'b1;
        pend_t_d[i] = post_t_q[i];
        if (pend_v_q[i] && !(move && sel == 2'(i)))
          ovf_set = 1'b1;
      end else if (move && sel == 2'(i)) begin
        pend_v_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        pend_t_q[i] <= '0;
        fifo_mem[i] <= '0;
      end
      pend_v_q    <= '0;
      ev_overflow <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++)
        pend_t_q[i] <= pend_t_d[i];
      pend_v_q <= pend_v_d;
      if (ovf_set)
        ev_overflow <= 1'b1;
      if (move) begin
        fifo_mem[wr_ptr] <= {pend_t_q[sel], sel};
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      case ({move, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_scan.sv
// Bench for button_event_scan: directed vector table plus randomized pins checked
// cycle by cycle against a streak-counting reference model.
module tb_button_event_scan;

  localparam int D = 8;
  localparam int L = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_n = 4'hF;
  logic       ev_ready = 1'b0;
  logic [3:0] btn_state;
  logic       ev_valid;
  logic [3:0] ev_code;
  logic       ev_overflow;

  int checks = 0;
  int passes = 0;
  bit model_on = 1'b0;

  button_event_scan #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .btn_state(btn_state),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_overflow(ev_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a level flips after D+1 consecutive opposite raw samples;
  // long fires after L-1 further pressed samples since the last (re)entry to pressed.
  logic [3:0] m_d1, m_d2, m_deb, m_state;
  int         m_opp [4];
  int         m_hold [4];
  bit         m_ldone [4];
  bit         m_pv [4];
  logic [1:0] m_pt [4];
  bit         m_pend [4];
  logic [1:0] m_ptype [4];
  logic [3:0] m_q [$];
  bit         m_ovf;

  always @(posedge clk or posedge rst) begin
    bit         pop, can;
    int         sel;
    logic [3:0] raw;
    if (rst) begin
      m_d1 = 4'hF; m_d2 = 4'hF; m_deb = 4'h0; m_state = 4'h0; m_ovf = 1'b0;
      m_q.delete();
      for (int i = 0; i < 4; i++) begin
        m_opp[i] = 0; m_hold[i] = 0; m_ldone[i] = 1'b0;
        m_pv[i] = 1'b0; m_pt[i] = 2'b00; m_pend[i] = 1'b0; m_ptype[i] = 2'b00;
      end
    end else begin
      pop = (m_q.size() > 0) && ev_ready;
      can = (m_q.size() < 4) || pop;
      sel = -1;
      for (int i = 0; i < 4; i++)
        if (sel < 0 && m_pend[i]) sel = i;
      if (pop) void'(m_q.pop_front());
      if (sel >= 0 && can) m_q.push_back({m_ptype[sel], 2'(sel)});
      else sel = -1;
      for (int i = 0; i < 4; i++) begin
        if (m_pv[i]) begin
          if (m_pend[i] && i != sel) m_ovf = 1'b1;
          m_pend[i] = 1'b1;
          m_ptype[i] = m_pt[i];
        end else if (i == sel) begin
          m_pend[i] = 1'b0;
        end
      end
      raw = ~m_d2;
      m_d2 = m_d1;
      m_d1 = btn_n;
      m_state = m_deb;
      for (int i = 0; i < 4; i++) begin
        m_pv[i] = 1'b0;
        if (raw[i] != m_deb[i]) begin
          m_opp[i]++;
          if (m_opp[i] == D + 1) begin
            m_deb[i] = raw[i];
            m_opp[i] = 0;
            m_pv[i] = 1'b1;
            m_pt[i] = raw[i] ? 2'b01 : 2'b10;
            m_hold[i] = 0;
            if (!raw[i]) m_ldone[i] = 1'b0;
          end
        end else begin
          if (m_deb[i]) begin
            if (m_opp[i] > 0) m_hold[i] = 0;
            else if (!m_ldone[i]) begin
              m_hold[i]++;
              if (m_hold[i] == L - 1) begin
                m_ldone[i] = 1'b1;
                m_pv[i] = 1'b1;
                m_pt[i] = 2'b11;
              end
            end
          end
          m_opp[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic       exp_v;
    logic [3:0] exp_c;
    if (model_on) begin
      exp_v = (m_q.size() > 0);
      exp_c = exp_v ? m_q[0] : 4'h0;
      checks++;
      if (btn_state === m_state && ev_valid === exp_v && ev_overflow === m_ovf &&
          (!exp_v || ev_code === exp_c))
        passes++;
      else
        $display("FAIL model t=%0t state=%b/%b valid=%b/%b code=%b/%b ovf=%b/%b (got/required)",
                 $time, btn_state, m_state, ev_valid, exp_v, ev_code, exp_c, ev_overflow, m_ovf);
    end
  end

  typedef struct {
    bit         rst;
    logic [3:0] btn;
    bit         rdy;
    int         n;
    logic [3:0] st;
    bit         vld;
    logic [3:0] code;
    bit         ovf;
    bit         ckc;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(bit r, logic [3:0] b, bit rd, int n, logic [3:0] st,
                              bit v, logic [3:0] c, bit o, bit ck);
    vec_t x;
    x.rst = r; x.btn = b; x.rdy = rd; x.n = n; x.st = st;
    x.vld = v; x.code = c; x.ovf = o; x.ckc = ck;
    return x;
  endfunction

  // Called at a falling edge: drive, run n rising edges, compare at the next falling edge.
  task automatic run_vec(input vec_t v, input int idx);
    #1;
    rst = v.rst; btn_n = v.btn; ev_ready = v.rdy;
    repeat (v.n) @(posedge clk);
    @(negedge clk);
    checks++;
    if (btn_state === v.st && ev_valid === v.vld && ev_overflow === v.ovf &&
        (!v.ckc || ev_code === v.code))
      passes++;
    else
      $display("FAIL vec%0d state=%b/%b valid=%b/%b code=%b/%b ovf=%b/%b (got/required)",
               idx, btn_state, v.st, ev_valid, v.vld, ev_code, v.code, ev_overflow, v.ovf);
  endtask

  int         async_at;
  int         hold_left [4];
  logic [3:0] pins;
  int         mode;

  initial begin
    // reset state
    vecs.push_back(mk(1, 4'hF, 0, 2, 4'h0, 0, 4'h0, 0, 1));
    // button 2 held 20 cycles: rises at edge 11, single press event 0110
    vecs.push_back(mk(0, 4'hB, 1, 11, 4'h0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hB, 1, 1,  4'h4, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hB, 1, 1,  4'h4, 1, 4'h6, 0, 1));
    vecs.push_back(mk(0, 4'hB, 1, 1,  4'h4, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hB, 1, 6,  4'h4, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 1, 11, 4'h4, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 1, 1,  4'h0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 1, 1,  4'h0, 1, 4'hA, 0, 1));
    vecs.push_back(mk(0, 4'hF, 1, 1,  4'h0, 0, 4'h0, 0, 0));
    // short glitch on button 0: nothing happens
    vecs.push_back(mk(1, 4'hF, 1, 2,  4'h0, 0, 4'h0, 0, 1));
    vecs.push_back(mk(0, 4'hE, 1, 5,  4'h0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 1, 20, 4'h0, 0, 4'h0, 0, 0));
    // button 1 held 60 cycles: press, long, release
    vecs.push_back(mk(0, 4'hD, 1, 12, 4'h2, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hD, 1, 1,  4'h2, 1, 4'h5, 0, 1));
    vecs.push_back(mk(0, 4'hD, 1, 1,  4'h2, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hD, 1, 29, 4'h2, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hD, 1, 1,  4'h2, 1, 4'hD, 0, 1));
    vecs.push_back(mk(0, 4'hD, 1, 1,  4'h2, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hD, 1, 15, 4'h2, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 1, 11, 4'h2, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 1, 1,  4'h0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 1, 1,  4'h0, 1, 4'h9, 0, 1));
    vecs.push_back(mk(0, 4'hF, 1, 1,  4'h0, 0, 4'h0, 0, 0));
    // all pressed together, consumer stalled, then drained in order
    vecs.push_back(mk(1, 4'hF, 0, 2,  4'h0, 0, 4'h0, 0, 1));
    vecs.push_back(mk(0, 4'h0, 0, 12, 4'hF, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'h0, 0, 1,  4'hF, 1, 4'h4, 0, 1));
    vecs.push_back(mk(0, 4'h0, 0, 3,  4'hF, 1, 4'h4, 0, 1));
    vecs.push_back(mk(0, 4'h0, 1, 1,  4'hF, 1, 4'h5, 0, 1));
    vecs.push_back(mk(0, 4'h0, 1, 1,  4'hF, 1, 4'h6, 0, 1));
    vecs.push_back(mk(0, 4'h0, 1, 1,  4'hF, 1, 4'h7, 0, 1));
    vecs.push_back(mk(0, 4'h0, 1, 1,  4'hF, 0, 4'h0, 0, 0));
    // FIFO full, button 0 released then re-pressed: second post lands on occupied slot
    vecs.push_back(mk(1, 4'hF, 0, 2,  4'h0, 0, 4'h0, 0, 1));
    vecs.push_back(mk(0, 4'h0, 0, 16, 4'hF, 1, 4'h4, 0, 1));
    vecs.push_back(mk(0, 4'h1, 0, 14, 4'hE, 1, 4'h4, 0, 1));
    vecs.push_back(mk(0, 4'h0, 0, 11, 4'hE, 1, 4'h4, 0, 1));
    vecs.push_back(mk(0, 4'h0, 0, 1,  4'hF, 1, 4'h4, 1, 1));
    async_at = vecs.size();
    // buttons held through reset: a full debounce window is needed again
    vecs.push_back(mk(1, 4'h0, 1, 2,  4'h0, 0, 4'h0, 0, 1));
    vecs.push_back(mk(0, 4'h0, 1, 11, 4'h0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'h0, 1, 1,  4'hF, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'h0, 1, 1,  4'hF, 1, 4'h4, 0, 1));
    vecs.push_back(mk(0, 4'h0, 1, 1,  4'hF, 1, 4'h5, 0, 1));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      if (i == async_at) begin
        #1 rst = 1'b1;
        #1;
        checks++;
        if (btn_state === 4'h0 && ev_valid === 1'b0 && ev_code === 4'h0 && ev_overflow === 1'b0)
          passes++;
        else
          $display("FAIL async_reset state=%b valid=%b code=%b ovf=%b required all zero",
                   btn_state, ev_valid, ev_code, ev_overflow);
        @(negedge clk);
      end
      run_vec(vecs[i], i);
      if (i == 0) model_on = 1'b1;
    end

    // randomized pins with bounce, stalls and one mid-run reset
    run_vec(mk(1, 4'hF, 1, 2, 4'h0, 0, 4'h0, 0, 1), vecs.size());
    pins = 4'hF;
    mode = 0;
    for (int b = 0; b < 4; b++) hold_left[b] = 0;
    for (int c = 0; c < 4000; c++) begin
      #1;
      if (c % 64 == 0) mode = $urandom_range(0, 2);
      for (int b = 0; b < 4; b++) begin
        if (hold_left[b] == 0) begin
          pins[b] = 1'($urandom_range(0, 1));
          hold_left[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 60);
        end
        hold_left[b]--;
      end
      btn_n = pins;
      case (mode)
        0:       ev_ready = 1'b1;
        1:       ev_ready = ($urandom_range(0, 3) != 0);
        default: ev_ready = ($urandom_range(0, 7) == 0);
      endcase
      rst = (c == 2000);
      @(negedge clk);
    end

    model_on = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/button_event_scan.md
BUTTON_EVENT_SCAN -- requirements
Module: button_event_scan

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 120000, is the stable-input time in clk cycles (10 ms at 12 MHz); legal range 2..2^24-1.
REQ-002 Parameter LONG_CYCLES, default 12000000, is the hold time in clk cycles after debounced press before a long-press event (1 s); legal range 2..2^24-1.
REQ-003 Port clk, input, 1 bit: 12 MHz system clock; all logic on posedge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port btn_n, input, 4 bits: raw push-button pins, active low, asynchronous to clk.
REQ-006 Port btn_state, output, 4 bits: debounced level per button, 1 = pressed.
REQ-007 Port ev_valid, output, 1 bit: event FIFO non-empty.
REQ-008 Port ev_ready, input, 1 bit: consumer accepts head event.
REQ-009 Port ev_code, output, 4 bits: {type[1:0], button[1:0]}; type 01 press, 10 release, 11 long; 00 never emitted.
REQ-010 Port ev_overflow, output, 1 bit: sticky, an event was lost.

Function
REQ-011 Each btn_n bit SHALL pass through a 2-flop synchronizer with reset value 1; downstream logic SHALL use only the inverted second-stage output (raw_pressed).
REQ-012 Each button SHALL have an independent FSM with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT and a 24-bit counter.
- RELEASED: raw_pressed=1 -> PRESS_WAIT, counter=0.
- PRESS_WAIT: raw_pressed=0 -> RELEASED; else counter==DEBOUNCE_CYCLES-1 -> PRESSED, counter=0, post press event; else counter+1.
- PRESSED: raw_pressed=0 -> RELEASE_WAIT, counter=0; else counter saturates at LONG_CYCLES-1, posting one long event the cycle it reaches LONG_CYCLES-1.
- RELEASE_WAIT: raw_pressed=1 -> PRESSED with counter preserved as LONG_CYCLES-1 if the long event was already posted, else reset to 0; else counter==DEBOUNCE_CYCLES-1 -> RELEASED, post release event; else counter+1.
REQ-013 A long event SHALL be posted at most once per debounced press; the flag is cleared on entry to RELEASED.
REQ-014 btn_state[i] SHALL be 1 in PRESSED and RELEASE_WAIT, 0 otherwise (registered state decode, no combinational path from btn_n).
REQ-015 Latency: a pin held low from sampling edge E SHALL make btn_state rise, and post a press event, at edge E+DEBOUNCE_CYCLES+3.
REQ-016 Each button SHALL own one pending slot (valid + type); posting into an occupied slot SHALL overwrite it and set ev_overflow.
REQ-017 An arbiter SHALL move at most one pending slot per cycle into the FIFO, lowest button index first, only when the FIFO is not full or is popped in the same cycle; the moved slot clears that cycle, unless the same button posts that cycle, in which case the new event occupies the slot without overflow.
REQ-018 The FIFO SHALL be 4 entries, first-in first-out, with ev_code driven from the registered head entry; ev_valid=1 iff count>0.
REQ-019 Pop SHALL occur on ev_valid && ev_ready; pop on empty SHALL be ignored; simultaneous push and pop SHALL keep the count unchanged, including when full.
REQ-020 ev_code and ev_valid SHALL hold stable while ev_valid && !ev_ready.
REQ-021 ev_overflow SHALL clear only on reset.

Reset
REQ-022 On rst=1, asynchronously: synchronizers=1, all FSMs RELEASED, counters 0, long flags 0, pending slots empty, FIFO empty, btn_state=0, ev_valid=0, ev_code=0, ev_overflow=0.
REQ-023 Reset asserted mid-debounce or mid-handshake SHALL discard all in-flight state; no event SHALL be emitted for a button still held at reset release until a full DEBOUNCE_CYCLES press window elapses.

Verification (DEBOUNCE_CYCLES=8, LONG_CYCLES=32)
REQ-024 btn_n[2] low 20 cycles, ev_ready=1 -> btn_state[2] rises at edge 11; one event 0110.
REQ-025 btn_n[0] low 5 cycles then high -> no btn_state change, no event.
REQ-026 btn_n[1] held 60 cycles then released, ev_ready=1 -> events 0101, 1101, 1001 in order; exactly one long event.
REQ-027 All buttons pressed same edge, ev_ready=0 -> FIFO fills with 0100, 0101, 0110, 0111, in that order; ev_overflow stays 0.
REQ-028 Same, then a full press/release of button 0 with ev_ready=0 -> ev_overflow=1; rst pulse mid-sequence -> all outputs 0 next cycle.
